toggle_stream_encoder: RTL and testbench

//  Transmit side of the toggle-coded serial line. Accepts parallel words on a valid/ready

---
 rtl/toggle_stream_encoder_pkg.sv | 26 ++
 rtl/toggle_rx_model.sv | 24 ++
 rtl/toggle_stream_encoder.sv | 146 ++++++++++++++
 tb/tb_toggle_stream_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/toggle_stream_encoder_pkg.sv
// Shared types and helpers for the toggle-coded serial transmitter.
// Holds the frame state enum and the single-bit toggle encoding rule.
package tse_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      GAP  = 3'd4
   } tse_state_e;

   // tx=1 holds the receiver level and tx=0 flips it, so XNOR yields the bit that lands on d.
   function automatic logic tse_enc(input logic model, input logic d);
      return ~(model ^ d);
   endfunction

   function automatic int tse_max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/toggle_rx_model.sv
// Two-state toggle receiver: holds its level on in=1 and flips it on in=0.
// Resets to 1. Used as the transmitter's mirror of the far-end receiver.
module toggle_rx_model (
   input  logic clk,
   input  logic areset_n,
   input  logic rx_in,
   output logic rx_q
);

   logic rx_d;

   always_comb begin
      rx_d = rx_in ? rx_q : ~rx_q;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         rx_q <= 1'b1;
      end else begin
         rx_q <= rx_d;
      end
   end

endmodule

// File: rtl/toggle_stream_encoder.sv
// Transmit side of the toggle-coded serial line: frames each accepted word as
// preamble, LSB-first data, optional even parity and idle gap, toggle-encoded on tx.
module toggle_stream_encoder
   import tse_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PRE_LEN   = 2,
   parameter int PARITY_EN = 1,
   parameter int GAP_LEN   = 1
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              tx,
   output logic              model_q,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_MAX = tse_max3(DATA_W, PRE_LEN, GAP_LEN);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

   tse_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              lvl_nxt;
   logic              emit;
   logic              tgt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      par_d   = par_q;

      unique case (state_q)
         IDLE: begin
            if (s_valid) begin
               state_d = PRE;
               cnt_d   = '0;
               sreg_d  = s_data;
               par_d   = ^s_data;
            end
         end
         PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == DATA_LAST) begin
               state_d = (PARITY_EN != 0) ? PAR : GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PAR: begin
            state_d = GAP;
            cnt_d   = '0;
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Receiver level once it has clocked the tx bit currently on the line.
      lvl_nxt = tx_q ? model_q : ~model_q;

      emit = 1'b0;
      tgt  = lvl_nxt;
      case (state_d)
         PRE: begin
            emit = 1'b1;
            tgt  = ~lvl_nxt;
         end
         DATA: begin
            emit   = 1'b1;
            tgt    = sreg_q[0];
            sreg_d = sreg_q >> 1;
         end
         PAR: begin
            emit = 1'b1;
            tgt  = par_q;
         end
         default: begin
            emit = 1'b0;
         end
      endcase

      tx_d   = emit ? tse_enc(lvl_nxt, tgt) : 1'b1;
      done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   toggle_rx_model u_rx_model (
      .clk      (clk),
      .areset_n (areset_n),
      .rx_in    (tx_q),
      .rx_q     (model_q)
   );

   assign tx         = tx_q;
   assign frame_done = done_q;
   assign s_ready    = (state_q == IDLE);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_toggle_stream_encoder.sv
// Bench for toggle_stream_encoder: default build plus a no-parity, 3-cycle-preamble build,
// each decoded by its own toggle_rx_model against frames rebuilt from the framing rules.
module tb_toggle_stream_encoder;

   logic       clk;
   logic       areset_n;

   logic       s_valid_a, s_ready_a, tx_a, model_a, busy_a, done_a, rx_a;
   logic [7:0] s_data_a;
   logic       s_valid_b, s_ready_b, tx_b, model_b, busy_b, done_b, rx_b;
   logic [7:0] s_data_b;

   int checks = 0;
   int errors = 0;
   logic lvl_a;
   logic lvl_b;

   toggle_stream_encoder #(.DATA_W(8), .PRE_LEN(2), .PARITY_EN(1), .GAP_LEN(1)) dut_a (
      .clk(clk), .areset_n(areset_n), .s_valid(s_valid_a), .s_data(s_data_a),
      .s_ready(s_ready_a), .tx(tx_a), .model_q(model_a), .busy(busy_a), .frame_done(done_a)
   );

   toggle_stream_encoder #(.DATA_W(8), .PRE_LEN(3), .PARITY_EN(0), .GAP_LEN(1)) dut_b (
      .clk(clk), .areset_n(areset_n), .s_valid(s_valid_b), .s_data(s_data_b),
      .s_ready(s_ready_b), .tx(tx_b), .model_q(model_b), .busy(busy_b), .frame_done(done_b)
   );

   toggle_rx_model dec_a (.clk(clk), .areset_n(areset_n), .rx_in(tx_a), .rx_q(rx_a));
   toggle_rx_model dec_b (.clk(clk), .areset_n(areset_n), .rx_in(tx_b), .rx_q(rx_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sends one word on the default build starting from an IDLE negedge. s_valid stays high
   // for the whole frame (it must be ignored while busy); returns on the first IDLE negedge.
   task automatic frame_a(input logic [7:0] w);
      logic [10:0] rb;
      logic [11:0] txe;
      logic        prev;
      logic        b;
      prev = lvl_a;
      for (int i = 0; i < 11; i++) begin
         if (i < 2)       b = ~prev;
         else if (i < 10) b = w[i-2];
         else             b = ^w;
         rb[i]  = b;
         txe[i] = (b == prev);
         prev   = b;
      end
      txe[11] = 1'b1;

      s_valid_a = 1'b1;
      s_data_a  = w;
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         s_data_a = 8'($urandom);
         chk("a_tx",      tx_a,      txe[k-1]);
         chk("a_ready",   s_ready_a, 1'b0);
         chk("a_busy",    busy_a,    1'b1);
         chk("a_done",    done_a,    (k == 12));
         chk("a_model",   model_a,   rx_a);
         chk("a_rx",      rx_a,      (k == 1) ? lvl_a : rb[k-2]);
      end
      @(negedge clk);
      chk("a_ready_end", s_ready_a, 1'b1);
      chk("a_done_end",  done_a,    1'b0);
      chk("a_tx_end",    tx_a,      1'b1);
      chk("a_rx_end",    rx_a,      rb[10]);
      lvl_a = rb[10];
   endtask

   initial begin
      logic [7:0] w;
      logic [7:0] dec;
      int         len;
      int         done_at;
      int         gap;
      logic       prevlvl;

      areset_n  = 1'b0;
      s_valid_a = 1'b0;
      s_data_a  = 8'h00;
      s_valid_b = 1'b0;
      s_data_b  = 8'h00;
      lvl_a     = 1'b1;
      lvl_b     = 1'b1;

      // Reset and idle
      repeat (3) @(negedge clk);
      chk("rst_tx",    tx_a,    1'b1);
      chk("rst_model", model_a, 1'b1);
      chk("rst_busy",  busy_a,  1'b0);
      chk("rst_done",  done_a,  1'b0);
      areset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_tx",    tx_a,      1'b1);
         chk("idle_model", model_a,   1'b1);
         chk("idle_ready", s_ready_a, 1'b1);
         chk("idle_busy",  busy_a,    1'b0);
         chk("idle_b_tx",  tx_b,      1'b1);
      end

      // Single frame 0xA5
      frame_a(8'hA5);
      s_valid_a = 1'b0;
      chk("a5_level", rx_a, 1'b0);
      repeat (2) @(negedge clk);

      // Back-to-back 0x00 then 0xFF with s_valid held high
      frame_a(8'h00);
      frame_a(8'hFF);
      s_valid_a = 1'b0;
      repeat (2) @(negedge clk);

      // Reset during DATA bit 3
      s_valid_a = 1'b1;
      s_data_a  = 8'($urandom);
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         s_valid_a = 1'b0;
      end
      areset_n = 1'b0;
      #1;
      chk("mid_rst_tx",    tx_a,      1'b1);
      chk("mid_rst_model", model_a,   1'b1);
      chk("mid_rst_ready", s_ready_a, 1'b1);
      chk("mid_rst_busy",  busy_a,    1'b0);
      @(negedge clk);
      areset_n = 1'b1;
      lvl_a = 1'b1;
      lvl_b = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", s_ready_a, 1'b1);
      chk("post_rst_tx",    tx_a,      1'b1);
      frame_a(8'($urandom));
      s_valid_a = 1'b0;
      frame_a(8'h3C);
      s_valid_a = 1'b0;

      // Random words on the no-parity build, decoded by the bench receiver
      for (int n = 0; n < 200; n++) begin
         w   = 8'($urandom);
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         s_valid_b = 1'b1;
         s_data_b  = w;
         prevlvl   = lvl_b;
         @(posedge clk);
         len     = 0;
         done_at = 0;
         dec     = 8'h00;
         for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!busy_b) begin
               s_valid_b = 1'b0;
               break;
            end
            len++;
            s_valid_b = 1'($urandom);
            s_data_b  = 8'($urandom);
            if (done_b) done_at = k;
            if (k >= 2 && k <= 4) chk("b_pre", rx_b, prevlvl ^ (k % 2 == 0));
            if (k >= 5 && k <= 12) dec[k-5] = rx_b;
            chk("b_model", model_b, rx_b);
         end
         s_valid_b = 1'b0;
         chk("b_len",  len,     12);
         chk("b_done", done_at, 12);
         chk("b_word", dec,     w);
         lvl_b = dec[7];
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
